// File: rtl/taco_order_decoder.sv
// Taco order decoder: turns "<flavour letter><quantity digit>" byte pairs into
// a stream of one-hot flavour tokens, one per taco, and keeps saturating
// per-flavour tallies of the tokens delivered.
module taco_order_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       out_sabor,
    input  logic             out_ready,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_p,
    output logic [CNT_W-1:0] cnt_f,
    output logic [CNT_W-1:0] cnt_d
);

    typedef enum logic [1:0] {StIdle, StQty, StEmit} state_e;

    state_e           state_q, state_d;
    logic [3:0]       flav_q, flav_d;
    logic [3:0]       rem_q, rem_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d_arr [4];

    logic accept;
    logic handshake;

    // Map an ASCII flavour letter to its one-hot code; zero for anything else.
    function automatic logic [3:0] letter_code(input logic [7:0] b);
        logic [3:0] code;
        code = 4'b0000;
        unique case (b)
            8'd67:   code = 4'b0001;
            8'd80:   code = 4'b0010;
            8'd70:   code = 4'b0100;
            8'd68:   code = 4'b1000;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Handshake-facing outputs derived purely from the current state.
    always_comb begin
        in_ready  = (state_q != StEmit);
        out_valid = (state_q == StEmit);
        out_sabor = (state_q == StEmit) ? flav_q : 4'b0000;
        busy      = (state_q != StIdle);
        err       = err_q;
        cnt_c     = cnt_q[0];
        cnt_p     = cnt_q[1];
        cnt_f     = cnt_q[2];
        cnt_d     = cnt_q[3];
    end

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Order parsing and token emission next-state logic.
    always_comb begin
        state_d = state_q;
        flav_d  = flav_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (letter_code(in_data) != 4'b0000) begin
                        flav_d  = letter_code(in_data);
                        state_d = StQty;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StQty: begin
                if (accept) begin
                    if (in_data >= 8'd49 && in_data <= 8'd57) begin
                        rem_d   = 4'(in_data - 8'd48);
                        state_d = StEmit;
                    end else begin
                        // '0' cancels silently; anything else is rejected.
                        err_d   = (in_data != 8'd48);
                        flav_d  = 4'b0000;
                        state_d = StIdle;
                    end
                end
            end
            StEmit: begin
                if (handshake) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        flav_d  = 4'b0000;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                flav_d  = 4'b0000;
                rem_d   = 4'd0;
            end
        endcase
    end

    // Saturating tally of delivered tokens per flavour.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d_arr[i] = cnt_q[i];
            if (handshake && flav_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d_arr[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            flav_q  <= 4'b0000;
            rem_q   <= 4'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            flav_q  <= flav_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_taco_order_decoder.sv
// Scoreboard bench for taco_order_decoder: an order-level model pushes the
// expected tokens, a negedge monitor pops and compares on each handshake.
module tb_taco_order_decoder;

    localparam int unsigned CW = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [3:0]    out_sabor;
    logic          out_ready;
    logic          err;
    logic          busy;
    logic [CW-1:0] cnt_c, cnt_p, cnt_f, cnt_d;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_q[$];          // expected flavour index per token
    int tally[4];          // tokens delivered per flavour (model)
    int err_exp  = 0;
    int err_seen = 0;
    int hs_cnt   = 0;
    bit m_have   = 0;      // model: flavour letter pending
    int m_flav   = 0;
    bit rand_rdy = 0;

    taco_order_decoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_sabor(out_sabor),
        .out_ready(out_ready), .err(err), .busy(busy),
        .cnt_c(cnt_c), .cnt_p(cnt_p), .cnt_f(cnt_f), .cnt_d(cnt_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int letter_idx(input int b);
        case (b)
            67: return 0;
            80: return 1;
            70: return 2;
            68: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one byte until accepted, then apply the order rules to the model.
    task automatic send_byte(input int b);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = 8'(b);
        for (int i = 0; i < 300 && !done; i++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        if (!m_have) begin
            if (letter_idx(b) >= 0) begin
                m_have = 1;
                m_flav = letter_idx(b);
            end else begin
                err_exp++;
            end
        end else begin
            m_have = 0;
            if (b >= 49 && b <= 57) begin
                for (int k = 0; k < b - 48; k++) exp_q.push_back(m_flav);
            end else if (b != 48) begin
                err_exp++;
            end
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (exp_q.size() == 0) done = 1;
            tick();
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_cnt_c"}, int'(cnt_c), sat(tally[0]));
        check({tag, "_cnt_p"}, int'(cnt_p), sat(tally[1]));
        check({tag, "_cnt_f"}, int'(cnt_f), sat(tally[2]));
        check({tag, "_cnt_d"}, int'(cnt_d), sat(tally[3]));
        check({tag, "_err_count"}, err_seen, err_exp);
    endtask

    // Monitor: token check on handshake, idle-zero, one-hot and hold stability.
    bit         prev_hold = 0;
    logic [3:0] prev_sabor;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (err) err_seen++;
            if (prev_hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_sabor", int'(out_sabor), int'(prev_sabor));
            end
            if (!out_valid && out_sabor != 4'b0000) check("idle_sabor", int'(out_sabor), 0);
            if (out_valid && !$onehot(out_sabor)) check("onehot", int'(out_sabor), 1);
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_token", int'(out_sabor), 0);
                end else begin
                    int idx;
                    idx = exp_q.pop_front();
                    check("token", int'(out_sabor), 1 << idx);
                    tally[idx]++;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_sabor = out_sabor;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs0;
        for (int i = 0; i < 4; i++) tally[i] = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sabor", int'(out_sabor), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check_cnts("rst");

        // 2: 'C','3' with out_ready held high
        out_ready = 1'b1;
        send_byte(67);
        check("qty_busy", int'(busy), 1);
        send_byte(51);
        check("emit_in_ready", int'(in_ready), 0);
        check("emit_busy", int'(busy), 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) n++;
            else if (n > 0) break;
            tick();
        end
        check("c3_cycles", n, 3);
        check("c3_busy_after", int'(busy), 0);
        check("c3_in_ready_after", int'(in_ready), 1);
        check_cnts("c3");

        // 3: 'F','2' with out_ready 0,1,0,1
        out_ready = 1'b0;
        send_byte(70);
        send_byte(50);
        hs0 = hs_cnt;
        tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        check("f2_handshakes", hs_cnt - hs0, 2);
        check("f2_done_valid", int'(out_valid), 0);
        check_cnts("f2");

        // 4: rejected bytes and cancel
        send_byte(88);
        check("x_err_pulse", int'(err), 1);
        check("x_idle", int'(busy), 0);
        tick();
        check("x_err_low", int'(err), 0);
        send_byte(80);
        send_byte(65);
        check("pa_err_pulse", int'(err), 1);
        check("pa_idle", int'(busy), 0);
        send_byte(68);
        send_byte(48);
        check("d0_no_err", int'(err), 0);
        check("d0_in_ready", int'(in_ready), 1);
        check("d0_no_token", int'(out_valid), 0);
        send_byte(99);
        send_byte(33);
        tick();
        check_cnts("bad");

        // 5: saturation with 18 'D' tokens
        send_byte(68); send_byte(57);
        send_byte(68); send_byte(57);
        drain();
        check("sat_cnt_d", int'(cnt_d), CMAX);
        check_cnts("sat");

        // 6: reset after first handshake of 'P','5'
        send_byte(80);
        send_byte(53);
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) tally[i] = 0;
        m_have = 0;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_cnt_p", int'(cnt_p), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        send_byte(67);
        send_byte(49);
        drain();
        check("post_rst_cnt_c", int'(cnt_c), 1);
        check_cnts("post_rst");

        // Randomized byte stream with random consumer back-pressure
        rand_rdy = 1;
        for (int k = 0; k < 60; k++) begin
            int r;
            int b;
            r = int'($urandom_range(0, 9));
            case (r)
                0: b = 67; 1: b = 80; 2: b = 70; 3: b = 68;
                4: b = 99; 5: b = 88; 6: b = 53;
                default: b = int'($urandom_range(48, 57));
            endcase
            send_byte(b);
        end
        drain();
        tick();
        check("rand_idle", int'(out_valid), 0);
        check_cnts("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
